// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared types for the pipelined execute-stage ALU  |  Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [1:0] {
    OP_ALU  = 2'b01,
    OP_PASS = 2'b10
  } alu_op_e;

  typedef enum logic [3:0] {
    CTRL_AND = 4'd0,
    CTRL_OR  = 4'd1,
    CTRL_XOR = 4'd2,
    CTRL_NOT = 4'd3,
    CTRL_NEG = 4'd4,
    CTRL_SHL = 4'd5,
    CTRL_SHR = 4'd6,
    CTRL_ADD = 4'd7,
    CTRL_SUB = 4'd8,
    CTRL_MUL = 4'd9
  } alu_ctrl_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic negative;
    logic zero;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_pipe_if.sv
// ============================================================================
// alu_pipe_if : issue/writeback handshake bundle for alu_pipe  |  Rev 1.0
// ============================================================================
`default_nettype none

interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  alu_flags_t       flags;

  modport master (
    output in_valid, alu_op, ctrl, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, alu_op, ctrl, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// ============================================================================
// alu_mul_iter : LSB-first shift-add multiplier, one step per cycle  |  Rev 1.0
// ============================================================================
`default_nettype none

module alu_mul_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;

  // done is raised during the final step so the caller can leave its wait state on that same edge
  assign done_o    = busy_q && (cnt_q == LAST_STEP);
  assign busy_o    = busy_q;
  assign product_o = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// alu_pipe : handshaked execute-stage ALU with registered result and flags.
// ALU_FAST_MUL_EN selects a single-cycle multiplier instead of the iterative one.  |  Rev 1.0
// ============================================================================
`default_nettype none

module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [WIDTH-1:0] calc_res;
  logic             calc_c;
  logic             calc_v;
  logic [WIDTH:0]   sum;

  function automatic alu_flags_t mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    alu_flags_t f;
    f.carry    = c;
    f.overflow = v;
    f.negative = r[WIDTH-1];
    f.zero     = (r == '0);
    return f;
  endfunction

  assign bus.in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
`else
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic               is_mul;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign is_mul = (bus.alu_op == OP_ALU) && (bus.ctrl == CTRL_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (bus.a),
    .b_i       (bus.b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );
`endif

  always_comb begin
    calc_res = '0;
    calc_c   = 1'b0;
    calc_v   = 1'b0;
    sum      = '0;
    if (bus.alu_op == OP_PASS) begin
      calc_res = bus.a;
    end else if (bus.alu_op == OP_ALU) begin
      case (bus.ctrl)
        CTRL_AND: calc_res = bus.a & bus.b;
        CTRL_OR:  calc_res = bus.a | bus.b;
        CTRL_XOR: calc_res = bus.a ^ bus.b;
        CTRL_NOT: calc_res = ~bus.a;
        CTRL_NEG: calc_res = '0 - bus.a;
        CTRL_SHL: begin
          calc_res = {bus.a[WIDTH-2:0], 1'b0};
          calc_c   = bus.a[WIDTH-1];
        end
        CTRL_SHR: begin
          calc_res = {1'b0, bus.a[WIDTH-1:1]};
          calc_c   = bus.a[0];
        end
        CTRL_ADD: begin
          sum      = {1'b0, bus.a} + {1'b0, bus.b};
          calc_res = sum[WIDTH-1:0];
          calc_c   = sum[WIDTH];
          calc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        end
        CTRL_SUB: begin
          // the extra top bit of the difference is the unsigned borrow
          sum      = {1'b0, bus.a} - {1'b0, bus.b};
          calc_res = sum[WIDTH-1:0];
          calc_c   = sum[WIDTH];
          calc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        end
`ifdef ALU_FAST_MUL_EN
        CTRL_MUL: begin
          calc_res = fast_prod[WIDTH-1:0];
          calc_c   = |fast_prod[2*WIDTH-1:WIDTH];
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !bus.out_ready;
`ifndef ALU_FAST_MUL_EN
    mul_start   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifndef ALU_FAST_MUL_EN
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else
`endif
          begin
            result_d    = calc_res;
            flags_d     = mk_flags(calc_res, calc_c, calc_v);
            out_valid_d = 1'b1;
          end
        end
      end
`ifndef ALU_FAST_MUL_EN
      MUL: begin
        // a core that is no longer busy without finishing would strand the FSM; fall back to IDLE
        if (mul_done) begin
          state_d = DONE;
        end else if (!mul_busy) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (!out_valid_q || bus.out_ready) begin
          result_d    = mul_prod[WIDTH-1:0];
          flags_d     = mk_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// tb_alu_pipe : vector table + scoreboard bench for alu_pipe at WIDTH=16  |  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = W + 1;
`endif

  typedef struct {
    logic [1:0]   op;
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  typedef struct {
    int           id;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic rand_rdy;
  exp_t exp_q[$];
  exp_t e;
  vec_t vt[18];

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  // Reference behaviour written from integer arithmetic, flags packed as {C,V,N,Z}
  function automatic void model(input logic [1:0] op, input logic [3:0] ct, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r, output logic [3:0] f);
    int sa, sb, s;
    logic [31:0] p;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0;
    sa = $signed(a); sb = $signed(b);
    if (op == 2'b10) r = a;
    else if (op == 2'b01) begin
      case (ct)
        4'd0: r = a & b;
        4'd1: r = a | b;
        4'd2: r = a ^ b;
        4'd3: r = ~a;
        4'd4: r = W'(-sa);
        4'd5: begin r = W'(int'(a) * 2); c = (a >= 16'h8000); end
        4'd6: begin r = a / 2; c = (a % 2) != 0; end
        4'd7: begin p = 32'(a) + 32'(b); r = p[W-1:0]; c = p[W]; s = sa + sb; v = (s > 32767) || (s < -32768); end
        4'd8: begin r = W'(int'(a) - int'(b)); c = (a < b); s = sa - sb; v = (s > 32767) || (s < -32768); end
        4'd9: begin p = 32'(a) * 32'(b); r = p[W-1:0]; c = (p[31:16] != 0); end
        default: r = '0;
      endcase
    end
    f = {c, v, r[W-1], r == '0};
  endfunction

  // Presents one op, queues its expected result, returns once it has been accepted
  task automatic issue(input int id, input logic [1:0] op, input logic [3:0] ct, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic [3:0] flg);
    int   n;
    logic acc;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.ctrl     = ct;
    bus.a        = a;
    bus.b        = b;
    exp_q.push_back('{id, res, flg});
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout_%0d: in_ready never seen, required within 200 cycles", id);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got result=%h flags=%b, required no output", bus.result, bus.flags);
      end else begin
        e = exp_q.pop_front();
        if (bus.result !== e.res || bus.flags !== e.flg) begin
          errors++;
          $display("FAIL result_%0d: got result=%h flags=%b, required result=%h flags=%b",
                   e.id, bus.result, bus.flags, e.res, e.flg);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] r, ra, rb;
    logic [3:0]   f, rc;
    logic [1:0]   ro;
    int           n;
    logic         rdy_bad;

    vt[0]  = '{2'b01, 4'd7, 16'h7FFF, 16'h0001, 16'h8000, 4'b0110};
    vt[1]  = '{2'b01, 4'd7, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001};
    vt[2]  = '{2'b01, 4'd8, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010};
    vt[3]  = '{2'b01, 4'd4, 16'h0001, 16'h0000, 16'hFFFF, 4'b0010};
    vt[4]  = '{2'b01, 4'd9, 16'h0102, 16'h0003, 16'h0306, 4'b0000};
    vt[5]  = '{2'b01, 4'd9, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b1000};
    vt[6]  = '{2'b10, 4'd0, 16'h1234, 16'h5678, 16'h1234, 4'b0000};
    vt[7]  = '{2'b11, 4'd7, 16'h1234, 16'h5678, 16'h0000, 4'b0001};
    vt[8]  = '{2'b01, 4'hC, 16'h1234, 16'h5678, 16'h0000, 4'b0001};
    vt[9]  = '{2'b01, 4'd0, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0010};
    vt[10] = '{2'b01, 4'd1, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000};
    vt[11] = '{2'b01, 4'd2, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001};
    vt[12] = '{2'b01, 4'd3, 16'h0000, 16'h1111, 16'hFFFF, 4'b0010};
    vt[13] = '{2'b01, 4'd5, 16'h8001, 16'h0000, 16'h0002, 4'b1000};
    vt[14] = '{2'b01, 4'd6, 16'h8001, 16'h0000, 16'h4000, 4'b1000};
    vt[15] = '{2'b01, 4'd8, 16'h8000, 16'h0001, 16'h7FFF, 4'b0100};
    vt[16] = '{2'b00, 4'd7, 16'h5555, 16'h0001, 16'h0000, 4'b0001};
    vt[17] = '{2'b01, 4'd9, 16'h0000, 16'h1234, 16'h0000, 4'b0001};

    checks = 0; errors = 0; rand_rdy = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.alu_op = 2'b00; bus.ctrl = 4'd0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {bus.out_valid, bus.result, 4'(bus.flags)}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", bus.in_ready, 1);

    // Vector table under randomly toggling downstream readiness
    rand_rdy = 1'b1;
    for (int i = 0; i < 18; i++) begin
      issue(i, vt[i].op, vt[i].ctrl, vt[i].a, vt[i].b, vt[i].res, vt[i].flg);
    end
    rand_rdy = 1'b0;
    drain();

    // Multiplier latency and issue-side back-pressure
    bus.in_valid = 1'b1; bus.alu_op = 2'b01; bus.ctrl = 4'd9; bus.a = 16'h0102; bus.b = 16'h0003;
    exp_q.push_back('{100, 16'h0306, 4'b0000});
    @(negedge clk);
    check("mul_accept_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0; rdy_bad = 1'b0;
    while (!bus.out_valid && n < 60) begin
      if (bus.in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("mul_latency", n, MUL_LAT);
    check("mul_in_ready_low", rdy_bad, 0);
    drain();

    // Stalled ADD result must hold, then consume-and-accept in one cycle
    bus.out_ready = 1'b0;
    issue(101, 2'b01, 4'd7, 16'h0001, 16'h0002, 16'h0003, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      check("stall_hold", {bus.out_valid, bus.in_ready, bus.result, 4'(bus.flags)}, {2'b10, 16'h0003, 4'b0000});
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1; bus.alu_op = 2'b01; bus.ctrl = 4'd7; bus.a = 16'h7FFF; bus.b = 16'h0001;
    bus.out_ready = 1'b1;
    exp_q.push_back('{102, 16'h8000, 4'b0110});
    @(negedge clk);
    check("consume_accept_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("next_result_valid", {bus.out_valid, bus.result}, {1'b1, 16'h8000});
    drain();

    // Reset during a multiply discards it entirely
    issue(103, 2'b01, 4'd9, 16'h00FF, 16'h00FF, 16'hFE01, 4'b0010);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midmul_reset_state", {bus.out_valid, bus.result, 4'(bus.flags)}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_state", {bus.in_ready, bus.out_valid, bus.result, 4'(bus.flags)}, {2'b10, 20'h0});
    n = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.out_valid) n++;
      @(posedge clk); #1;
    end
    check("no_partial_result", n, 0);

    // Random ops against the reference model
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      n  = $urandom_range(0, 7);
      ro = (n < 6) ? 2'b01 : (n == 6) ? 2'b10 : (($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11);
      rc = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = W'($urandom);
      model(ro, rc, ra, rb, r, f);
      issue(200 + i, ro, rc, ra, rb, r, f);
    end
    rand_rdy = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the team's combinational 16-bit ALU, for the execute stage of the pipelined CPU.
- Same op encoding (alu_op/ctrl), but:
  - generic WIDTH;
  - registered result with valid/ready flow control;
  - status flags;
  - iterative multi-cycle multiplier that back-pressures the issuing stage.
- Sits between the register-read/issue stage (upstream) and writeback (downstream).

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH+1), multiplier iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation this cycle
- alu_op  in  2  2'b10 pass A; 2'b01 ctrl-coded op; others produce 0
- ctrl  in  4  operation select when alu_op=2'b01
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- flags  out  4  {carry, overflow, negative, zero}, registered with result

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; out_valid=0; result=0; flags=0; counter and multiplier registers=0.
- Transfer rules:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - result and flags stable while out_valid && !out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready), so a result can be consumed and a new op accepted in the same cycle.
- Ops (alu_op=2'b01), all results truncated to WIDTH:
  - 0 AND, 1 OR, 2 XOR, 3 ~A, 4 0-A, 5 A<<1, 6 A>>1 (logical), 7 A+B, 8 A-B, 9 A*B (low WIDTH bits).
  - ctrl 10-15 -> 0.
- alu_op=2'b10 -> A. alu_op 2'b00/2'b11 -> 0.
- Flags:
  - zero = (result==0); negative = result[WIDTH-1].
  - ADD: carry = carry-out; overflow = signed overflow.
  - SUB: carry = borrow (A<B unsigned); overflow = signed overflow.
  - MUL: carry = (upper WIDTH bits of full product != 0); overflow = 0.
  - SL: carry = A[WIDTH-1]. SR: carry = A[0].
  - All other ops: carry = 0, overflow = 0.
- FSM states: IDLE, MUL, DONE.
  - IDLE, accepted non-MUL op: result/flags/out_valid=1 loaded on the same edge. Latency 1 cycle; stay IDLE.
  - IDLE, accepted MUL: latch A, B; clear accumulator; counter=0; -> MUL.
  - MUL: one shift-add step per cycle (multiplier LSB-first). After WIDTH steps -> DONE. in_ready=0 throughout.
  - DONE: if !out_valid || out_ready, load product and flags, set out_valid, -> IDLE. Otherwise wait in DONE.
  - MUL latency is WIDTH+1 cycles from acceptance to out_valid when downstream is not stalling.
- out_valid clears on output transfer unless a new result loads on the same edge.
- MUL edge cases: operand 0 still takes the full WIDTH iterations (fixed latency). Max × max yields low bits, with carry=1.
- rst_n asserted mid-MUL aborts the operation; no partial result is ever presented.

Optional Feature:
- Macro: ALU_FAST_MUL_EN.
- Defined: MUL is combinational, like other ops; latency 1; MUL/DONE states unused, in_ready never drops for MUL.
- Undefined: iterative multiplier as specified above.
- Result and flag values are identical in both builds; only timing differs.

Decomposition:
- Package alu_pkg:
  - typedef enum logic[1:0] alu_op_e (OP_ALU=2'b01, OP_PASS=2'b10);
  - typedef enum logic[3:0] alu_ctrl_e (CTRL_AND..CTRL_MUL);
  - typedef struct packed alu_flags_t {carry, overflow, negative, zero};
  - typedef enum alu_state_e (IDLE, MUL, DONE).
- Sub-module alu_mul_iter (start/busy/done, WIDTH-parametrised shift-add core, 2*WIDTH product). Instantiated only when ALU_FAST_MUL_EN is undefined.

Test Plan (all scenarios at WIDTH=16):
- Reset: rst_n=0 mid-MUL, then release -> out_valid=0, result=0, flags=0, in_ready=1 on the first cycle after release.
- ADD flags:
  - 0x7FFF+0x0001 -> result 0x8000, flags overflow=1, negative=1, carry=0.
  - 0xFFFF+0x0001 -> 0x0000, zero=1, carry=1.
- SUB and 0-A:
  - 0x0003-0x0005 -> 0xFFFE, carry(borrow)=1, negative=1.
  - ctrl=4 with A=0x0001 -> 0xFFFF.
- MUL timing:
  - 0x0102*0x0003 -> 0x0306 exactly 17 cycles after acceptance; in_ready=0 for those cycles.
  - 0xFFFF*0xFFFF -> 0x0001, carry=1.
  - With ALU_FAST_MUL_EN: same values, 1-cycle latency.
- Back-pressure: hold out_ready=0 for 5 cycles after an ADD result -> result/flags stable, in_ready=0. Raise out_ready with in_valid=1 -> one-cycle consume-and-accept, next result valid the following cycle.
- Illegal/pass encodings:
  - alu_op=2'b10, A=0x1234 -> 0x1234.
  - alu_op=2'b11 -> 0x0000, zero=1.
  - ctrl=4'hC -> 0x0000.
